cp0_unit: RTL and testbench

- Coprocessor-0 register file and exception/interrupt sequencer for the 5-stage MIPS pipeline.
- Consumes `mtc0` writes, exception requests and `eret` from the commit point; produces CP0 read data for `mfc0`, the interrupt-pending flag, and the one-cycle redirect to the exception vector or EPC.
- Owns the Count/Compare timer.

---
 rtl/cp0_unit_if.sv | 37 +++
 rtl/cp0_unit.sv | 149 ++++++++++++++
 tb/tb_cp0_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// Commit-point and decode-side signal bundle between the MIPS pipeline and CP0.
// The pipeline drives through the master modport and CP0 answers through the slave modport.
interface cp0_unit_if;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_in_ds;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic        int_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;

  modport master (
    output wen, waddr, wdata, raddr,
    output commit_valid, commit_pc, commit_in_ds,
    output exc_valid, exc_code, exc_badvaddr, eret, ext_int,
    input  rdata, int_pending, redirect_valid, redirect_pc, status, cause, epc
  );

  modport slave (
    input  wen, waddr, wdata, raddr,
    input  commit_valid, commit_pc, commit_in_ds,
    input  exc_valid, exc_code, exc_badvaddr, eret, ext_int,
    output rdata, int_pending, redirect_valid, redirect_pc, status, cause, epc
  );
endinterface

// File: rtl/cp0_unit.sv
// CP0 register file, Count/Compare timer and exception/interrupt/eret sequencer
// sitting at the commit point of the 5-stage MIPS pipeline.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input logic       clk,
  input logic       resetn,
  cp0_unit_if.slave bus
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic        cause_bd_q;
  logic        cause_ti_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exccode_q;
  logic        tick_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic [31:0] cause_w;
  logic        int_pending_w;
  logic        take_exc;
  logic        take_eret;
  logic        wen_eff;
  logic [4:0]  code_w;
  logic        count_wr;
  logic        compare_wr;
  logic [31:0] count_next;
  logic        tick_next;
  logic        ti_next;
  logic [31:0] rdata_w;

  // Non-writable Status bits always read back their reset constant.
  function automatic logic [31:0] merge_status(input logic [31:0] cur, input logic [31:0] wd);
    return (cur & ~STATUS_WMASK) | (wd & STATUS_WMASK);
  endfunction

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == 5'd4) || (code == 5'd5);
  endfunction

  assign cause_w = {cause_bd_q, cause_ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  assign int_pending_w = status_q[0] & ~status_q[1] & (|({ip_hw_q, ip_sw_q} & status_q[15:8]));

  assign take_exc  = bus.commit_valid & (int_pending_w | bus.exc_valid);
  assign take_eret = bus.commit_valid & bus.eret & ~take_exc;
  assign wen_eff   = bus.wen & ~take_exc & ~take_eret;
  assign code_w    = int_pending_w ? 5'd0 : bus.exc_code;

  // A Count write restarts the half-rate tick; a Compare write beats a same-cycle match.
  assign count_wr   = wen_eff && (bus.waddr == REG_COUNT);
  assign compare_wr = wen_eff && (bus.waddr == REG_COMPARE);
  assign count_next = count_wr ? bus.wdata : (tick_q ? count_q + 32'd1 : count_q);
  assign tick_next  = count_wr ? 1'b0 : ~tick_q;
  assign ti_next    = compare_wr ? 1'b0 : ((count_next == compare_q) ? 1'b1 : cause_ti_q);

  always_comb begin
    rdata_w = 32'd0;
    case (bus.raddr)
      REG_BADVADDR: rdata_w = badvaddr_q;
      REG_COUNT:    rdata_w = count_q;
      REG_COMPARE:  rdata_w = compare_q;
      REG_STATUS:   rdata_w = status_q;
      REG_CAUSE:    rdata_w = cause_w;
      REG_EPC:      rdata_w = epc_q;
      default:      rdata_w = 32'd0;
    endcase
    if (bus.wen && (bus.waddr == bus.raddr)) begin
      case (bus.raddr)
        REG_COUNT, REG_COMPARE, REG_EPC: rdata_w = bus.wdata;
        REG_STATUS: rdata_w = merge_status(status_q, bus.wdata);
        REG_CAUSE:  rdata_w = {cause_w[31:10], bus.wdata[9:8], cause_w[7:0]};
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q       <= 32'd0;
      count_q          <= 32'd0;
      compare_q        <= 32'd0;
      status_q         <= STATUS_RESET;
      epc_q            <= 32'd0;
      cause_bd_q       <= 1'b0;
      cause_ti_q       <= 1'b0;
      ip_hw_q          <= 6'd0;
      ip_sw_q          <= 2'd0;
      exccode_q        <= 5'd0;
      tick_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      count_q          <= count_next;
      tick_q           <= tick_next;
      cause_ti_q       <= ti_next;
      ip_hw_q          <= {bus.ext_int[5] | ti_next, bus.ext_int[4:0]};
      redirect_valid_q <= take_exc | take_eret;
      if (take_exc) begin
        // Nested exceptions keep the original return point.
        if (!status_q[1]) begin
          epc_q      <= bus.commit_in_ds ? bus.commit_pc - 32'd4 : bus.commit_pc;
          cause_bd_q <= bus.commit_in_ds;
        end
        status_q[1]   <= 1'b1;
        exccode_q     <= code_w;
        redirect_pc_q <= EXC_VECTOR;
        if (is_addr_exc(code_w)) begin
          badvaddr_q <= bus.exc_badvaddr;
        end
      end else if (take_eret) begin
        status_q[1]   <= 1'b0;
        redirect_pc_q <= epc_q;
      end else if (wen_eff) begin
        case (bus.waddr)
          REG_COMPARE: compare_q <= bus.wdata;
          REG_STATUS:  status_q  <= merge_status(status_q, bus.wdata);
          REG_CAUSE:   ip_sw_q   <= bus.wdata[9:8];
          REG_EPC:     epc_q     <= bus.wdata;
          default:     ;
        endcase
      end
    end
  end

  assign bus.rdata          = rdata_w;
  assign bus.int_pending    = int_pending_w;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.status         = status_q;
  assign bus.cause          = cause_w;
  assign bus.epc            = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: register/timer checks inline, redirect pulses
// matched against a queue of expected targets by a negedge monitor.
module tb_cp0_unit;
  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] v;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  cp0_unit_if bus();

  cp0_unit #(.EXC_VECTOR(32'hBFC0_0380), .STATUS_RESET(32'h0040_0000)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Every redirect pulse must consume exactly one expected target.
  always @(negedge clk) begin
    if (mon_en && resetn && bus.redirect_valid) begin
      if (exp_q.size() == 0) check("redirect_extra", {31'd0, bus.redirect_valid}, 32'd0);
      else check("redirect_pc", bus.redirect_pc, exp_q.pop_front());
    end
  end

  task automatic idle();
    bus.wen = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    bus.commit_valid = 1'b0; bus.commit_pc = 32'd0; bus.commit_in_ds = 1'b0;
    bus.exc_valid = 1'b0; bus.exc_code = 5'd0; bus.exc_badvaddr = 32'd0;
    bus.eret = 1'b0; bus.ext_int = 6'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    bus.raddr = a;
    #1;
    val = bus.rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
    idle();
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds, input logic [31:0] bva);
    bus.commit_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = code;
    bus.commit_pc = pc; bus.commit_in_ds = ds; bus.exc_badvaddr = bva;
    exp_q.push_back(VEC);
  endtask

  initial begin
    idle();
    bus.raddr = 5'd0;
    resetn = 1'b0;
    repeat (3) step();
    check("rst_status", bus.status, 32'h0040_0000);
    check("rst_cause", bus.cause, 32'h0);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_int_pending", {31'd0, bus.int_pending}, 32'd0);
    rd(5'd9, v); check("rst_count", v, 32'd0);

    mon_en = 1'b1;
    resetn = 1'b1;
    repeat (6) step();
    rd(5'd9, v); check("count_running", v, 32'd3);
    check("ti_match_zero", bus.cause, 32'h4000_8000);

    // Asynchronous reset mid-count.
    #1 resetn = 1'b0;
    #1;
    rd(5'd9, v); check("async_rst_count", v, 32'd0);
    check("async_rst_cause", bus.cause, 32'h0);
    check("async_rst_status", bus.status, 32'h0040_0000);
    check("async_rst_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    step();
    resetn = 1'b1;

    // Compare write on the first edge coincides with a Count==Compare match.
    mtc0(5'd11, 32'd5);
    check("compare_clear_wins", bus.cause, 32'h0);
    mtc0(5'd9, 32'd0);
    repeat (9) step();
    rd(5'd9, v); check("count_before_match", v, 32'd4);
    check("ti_before_match", bus.cause, 32'h0);
    step();
    rd(5'd9, v); check("count_at_match", v, 32'd5);
    check("ti_at_match", bus.cause, 32'h4000_8000);
    check("no_int_ie0", {31'd0, bus.int_pending}, 32'd0);

    mtc0(5'd12, 32'h0000_8001);
    check("status_write", bus.status, 32'h0040_8001);
    check("int_pending_set", {31'd0, bus.int_pending}, 32'd1);

    bus.commit_valid = 1'b1; bus.commit_pc = 32'h8000_0100;
    exp_q.push_back(VEC);
    step();
    idle();
    check("int_epc", bus.epc, 32'h8000_0100);
    check("int_cause", bus.cause, 32'h4000_8000);
    check("int_status_exl", bus.status, 32'h0040_8003);
    check("int_pending_exl", {31'd0, bus.int_pending}, 32'd0);

    mtc0(5'd11, 32'd100);
    check("ti_cleared", bus.cause, 32'h0);

    bus.commit_valid = 1'b1; bus.eret = 1'b1;
    exp_q.push_back(32'h8000_0100);
    step();
    idle();
    check("eret1_status", bus.status, 32'h0040_8001);

    // Address error in a delay slot, then a nested exception on the next cycle.
    exc(5'd4, 32'h8000_1004, 1'b1, 32'h0000_1233);
    step();
    check("adel_epc", bus.epc, 32'h8000_1000);
    check("adel_cause", bus.cause, 32'h8000_0010);
    check("adel_status", bus.status, 32'h0040_8003);
    rd(5'd8, v); check("adel_badvaddr", v, 32'h0000_1233);
    exc(5'd12, 32'h8000_2000, 1'b0, 32'h0000_FFFF);
    step();
    idle();
    check("nested_epc", bus.epc, 32'h8000_1000);
    check("nested_cause", bus.cause, 32'h8000_0030);
    rd(5'd8, v); check("nested_badvaddr", v, 32'h0000_1233);
    step();

    bus.commit_valid = 1'b1; bus.eret = 1'b1;
    exp_q.push_back(32'h8000_1000);
    step();
    idle();
    check("eret2_status", bus.status, 32'h0040_8001);

    exc(5'd10, 32'h8000_3000, 1'b0, 32'h0);
    bus.wen = 1'b1; bus.waddr = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    step();
    idle();
    check("exc_drops_wen_epc", bus.epc, 32'h8000_3000);
    check("exc_drops_wen_cause", bus.cause, 32'h0000_0028);

    bus.wen = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hFFFF_FF00;
    rd(5'd12, v); check("bypass_status", v, 32'h0040_FF00);
    step();
    idle();
    check("status_masked", bus.status, 32'h0040_FF00);

    bus.wen = 1'b1; bus.waddr = 5'd13; bus.wdata = 32'hFFFF_FFFF;
    rd(5'd13, v); check("bypass_cause", v, 32'h0000_0328);
    step();
    idle();
    check("cause_sw_ip", bus.cause, 32'h0000_0328);
    check("int_pending_ie0", {31'd0, bus.int_pending}, 32'd0);

    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h1234_5678;
    rd(5'd3, v); check("unmapped_read", v, 32'h0);
    step();
    bus.waddr = 5'd8; bus.wdata = 32'h0000_0055;
    rd(5'd8, v); check("badvaddr_ro_bypass", v, 32'h0000_1233);
    step();
    idle();
    rd(5'd8, v); check("badvaddr_ro", v, 32'h0000_1233);

    // Count wrap, then a load on a tick cycle.
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); check("wrap_load", v, 32'hFFFF_FFFF);
    step();
    rd(5'd9, v); check("wrap_hold", v, 32'hFFFF_FFFF);
    step();
    rd(5'd9, v); check("wrap_zero", v, 32'h0);
    step();
    rd(5'd9, v); check("wrap_zero_hold", v, 32'h0);
    mtc0(5'd9, 32'h0000_1000);
    rd(5'd9, v); check("tick_load", v, 32'h0000_1000);
    step();
    rd(5'd9, v); check("tick_load_hold", v, 32'h0000_1000);
    step();
    rd(5'd9, v); check("tick_load_inc", v, 32'h0000_1001);

    repeat (3) step();
    check("redirects_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
